// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one outstanding data-memory access with a req/gnt/rvalid
// handshake, byte-lane steering for stores and extension of load data for writeback.
module riscv_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [REG_ADDR-1:0]   req_rd_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_wb_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [REG_ADDR-1:0]   rsp_rd_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [REG_ADDR-1:0] rd_q;

  // funct3[1:0] is the access size (00 byte, 01 half, 10 word); funct3[2] marks unsigned loads.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    if (we) bad_f3 = (f3 > 3'd2);
    else    bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    return bad_f3 || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] k);
    case (f3[1:0])
      2'b00:   return 4'b0001 << k;
      2'b01:   return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] k,
                                                     input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] lane;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    lane = rd >> {k, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  return DATA_WIDTH'(b);
      3'b001:  return DATA_WIDTH'(h);
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: return rd;
    endcase
  endfunction

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_wb_o    <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_rd_o    <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          we_q     <= req_we_i;
          funct3_q <= req_funct3_i;
          off_q    <= req_addr_i[1:0];
          rd_q     <= req_rd_i;
          if (is_illegal(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
            // Rejected accesses skip memory and report straight away.
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_wb_o    <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_rd_o    <= req_rd_i;
          end else begin
            state       <= REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= req_we_i;
            mem_addr_o  <= {req_addr_i[DATA_WIDTH-1:2], 2'b00};
            mem_be_o    <= byte_en(req_funct3_i, req_addr_i[1:0]);
            mem_wdata_o <= req_we_i ? store_data(req_funct3_i, req_wdata_i) : '0;
          end
        end
        REQ: if (mem_gnt_i) begin
          state     <= WAIT;
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
        WAIT: if (mem_rvalid_i) begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rd_o    <= rd_q;
          rsp_wb_o    <= !we_q && (rd_q != '0);
          rsp_rdata_o <= we_q ? '0 : load_ext(funct3_q, off_q, mem_rdata_i);
        end
        default: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_wb_o    <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          rsp_rd_o    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the RV32I core. Sits directly downstream of execute: takes the ALU-computed effective address, rs2 store data and funct3 of a `LOAD_S`/`STORE_S` instruction. Runs a request/grant/response handshake with data memory. Returns a sign- or zero-extended load result, tagged with rd, to writeback. Misaligned or undefined accesses are rejected without touching memory.

## Interface
- `DATA_WIDTH`, 32, data and address width (`riscv_definitions::DATA_WIDTH`)
- `REG_ADDR`, 5, destination register index width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `req_valid_i` in 1: execute presents a memory operation
- `req_ready_o` out 1: LSU idle and can accept a request
- `req_we_i` in 1: 1 = store (`STORE_S`), 0 = load (`LOAD_S`)
- `req_funct3_i` in 3: `funct3_Type_LOAD` or `funct3_Type_STORE` encoding
- `req_addr_i` in 32: effective byte address
- `req_wdata_i` in 32: rs2 value for stores
- `req_rd_i` in 5: load destination register
- `mem_req_o` out 1: memory request
- `mem_we_o` out 1: memory write
- `mem_addr_o` out 32: word address, `{addr[31:2],2'b00}`
- `mem_be_o` out 4: byte enables
- `mem_wdata_o` out 32: lane-replicated store data
- `mem_gnt_i` in 1: memory accepted the request
- `mem_rvalid_i` in 1: memory response valid (loads and stores)
- `mem_rdata_i` in 32: memory read word
- `rsp_valid_o` out 1: one-cycle completion pulse
- `rsp_wb_o` out 1: write `rsp_rdata_o` to `rsp_rd_o`
- `rsp_rdata_o` out 32: extended load data
- `rsp_rd_o` out 5: destination register
- `rsp_err_o` out 1: misaligned or undefined funct3
- `busy_o` out 1: state != IDLE

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
  - IDLE: `req_ready_o=1`. On `req_valid_i`, latch we, funct3, addr, wdata and rd.
    - Legal access → REQ.
    - Illegal access → RESP with error set.
  - REQ: hold `mem_req_o=1` with stable `mem_*` outputs until `mem_gnt_i`, then go to WAIT.
  - WAIT: on `mem_rvalid_i`, capture the extended data and go to RESP.
  - RESP: `rsp_valid_o=1` for exactly one cycle, then IDLE.
- **Illegal access:**
  - LH/LHU/SH with `addr[0]=1`.
  - LW/SW with `addr[1:0]!=0`.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 of 011 or above.
- **Byte enables** (k = `addr[1:0]`):
  - Byte access: `0001<<k`, store data `{4{wdata[7:0]}}`.
  - Half access: `0011<<k`, store data `{2{wdata[15:0]}}`.
  - Word access: `1111`, store data `wdata`.
  - Loads drive the same enables with `mem_we_o=0`.
- **Load extraction:**
  - Byte lane = `rdata[8k+7:8k]`; half = `rdata[8k+15:8k]`.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- **Response fields:**
  - `rsp_wb_o=1` only for a legal load with `rd!=0`.
  - Stores and errors give `rsp_wb_o=0` and `rsp_rdata_o=0`.
- **Ignored handshake inputs:**
  - `mem_rvalid_i` is ignored outside WAIT, including rvalid asserted in the same cycle as gnt.
  - `mem_gnt_i` is ignored outside REQ.
- **Request acceptance:** `req_valid_i` is ignored when `req_ready_o=0`; execute stalls on `!req_ready_o`.

## Timing
- **Reset values:**
  - `rst` forces IDLE on the next edge.
  - Outputs after reset: `req_ready_o=1`; all other outputs 0 (`mem_*`, `rsp_*`, `busy_o`).
- **Reset mid-transaction:** the transaction is abandoned and no response is produced. A late `mem_rvalid_i` arriving in IDLE is ignored.
- **Registered outputs:** all `mem_*` and `rsp_*` outputs are registered. `req_ready_o` and `busy_o` decode the state.
- **Legal access latency:**
  - Accept in cycle N → `mem_req_o=1` in N+1.
  - gnt in cycle G (G≥N+1) → `mem_req_o=0` in G+1.
  - rvalid in cycle R (R≥G+1) → `rsp_valid_o=1` in R+1.
  - `req_ready_o=1` again in R+2.
  - Minimum load-to-response: 3 cycles (N+3).
- **Illegal access:** accept in N → `rsp_valid_o=1, rsp_err_o=1` in N+1, `mem_req_o` never asserted, IDLE in N+2.
- **Wait states:** unbounded gnt/rvalid stalls are allowed; `mem_*` outputs remain constant throughout REQ.
- **Outstanding requests:** at most one.

## Test plan
- **LW:**
  - Stimulus: addr 0x100, rd=5, gnt same cycle as req, rvalid next cycle with rdata 0xDEADBEEF.
  - Required response: `mem_be_o=1111`, `mem_addr_o=0x100`, rsp at N+3 with rdata 0xDEADBEEF, `rsp_wb_o=1`, rd=5.
- **LB/LBU:**
  - Stimulus: addr 0x103, rdata 0x80FF_0000.
  - Required response: `be=1000`; LB → 0xFFFFFF80; LBU → 0x00000080.
- **SH / SB:**
  - SH at addr 0x22, wdata 0x1234ABCD → `mem_addr_o=0x20`, `be=1100`, `wdata=0xABCDABCD`, `we=1`, response with `rsp_wb_o=0`.
  - SB at addr 0x21, wdata 0x55 → `be=0010`.
- **Misaligned LW:** addr 0x102 → no `mem_req_o`, `rsp_valid_o`+`rsp_err_o` at N+1, `rsp_wb_o=0`.
- **Stalls:**
  - Stimulus: gnt withheld 4 cycles, then rvalid 3 cycles later; a spurious rvalid pulsed during REQ.
  - Required response: `mem_*` stable while in REQ; spurious rvalid ignored; `req_ready_o=0` until the cycle after the rsp pulse.
- **Reset in WAIT:**
  - Stimulus: `rst` asserted during WAIT, then rvalid arrives after reset.
  - Required response: no `rsp_valid_o`, `req_ready_o=1`; a subsequent LW to rd=0 completes with `rsp_wb_o=0`.
